branch_trace_feeder: RTL and testbench

- Upstream stage of the branch history table.
- Accepts branch trace records (pc, taken, last) from the trace loader over a valid/ready handshake and buffers them in a FIFO.
- Replays them to the BHT at one record per cycle, with registered outputs and an explicit valid qualifier.
- Runs a small control FSM (idle/run/stall/done) and counts emitted records, so the testbench and top level know when a trace has been fully replayed.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 58 +++++
 rtl/branch_trace_feeder.sv | 115 +++++++++++
 tb/tb_branch_trace_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch trace feeder and the BHT front end.
// Trace record layout {last, taken, pc} and the feeder FSM encoding.
package bp_pkg;

  localparam int BP_PC_W = 9;
  localparam int BP_REC_W = BP_PC_W + 2;

  typedef struct packed {
    logic               last;
    logic               taken;
    logic [BP_PC_W-1:0] pc;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // Packed record width for a given pc width.
  function automatic int rec_w(input int pc_w);
    return pc_w + 2;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous circular FIFO holding trace records.
// Head entry is visible on rdata_o without a pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 11,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;

  // Storage write; contents need no reset since level gates reads.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/branch_trace_feeder.sv
// Buffers branch trace records and replays them to the BHT,
// one per cycle, under an idle/run/stall/done control FSM.
module branch_trace_feeder
  import bp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PC_W  = BP_PC_W,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic            in_taken,
  input  logic            in_last,
  input  logic            run,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic            out_taken,
  output logic            done,
  output logic [LW-1:0]   level,
  output logic [31:0]     emitted
);

  localparam int RW = rec_w(PC_W);

  feeder_state_e   state_q;
  logic            out_valid_q;
  logic [PC_W-1:0] out_pc_q;
  logic            out_taken_q;
  logic            done_q;
  logic [31:0]     emitted_q;

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [RW-1:0]   wdata;
  logic [RW-1:0]   rdata;
  logic            rd_last;
  logic            rd_taken;
  logic [PC_W-1:0] rd_pc;

  // A full FIFO refuses data even if the head leaves this cycle.
  assign in_ready = reset && !full && (state_q != ST_DONE);
  assign push     = in_valid && in_ready;
  assign pop      = reset && run && !empty && (state_q != ST_DONE);
  assign wdata    = {in_last, in_taken, in_pc};

  assign rd_last  = rdata[RW-1];
  assign rd_taken = rdata[RW-2];
  assign rd_pc    = rdata[PC_W-1:0];

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Control FSM with registered output record, done flag and count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_taken_q <= 1'b0;
      done_q      <= 1'b0;
      emitted_q   <= '0;
    end else begin
      unique case (state_q)
        ST_DONE: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
          if (!run) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            emitted_q <= '0;
          end
        end
        default: begin
          if (pop) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= rd_pc;
            out_taken_q <= rd_taken;
            emitted_q   <= emitted_q + 32'd1;
            state_q     <= rd_last ? ST_DONE : ST_RUN;
          end else if (run) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_STALL;
          end else begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_taken = out_taken_q;
  assign done      = done_q;
  assign emitted   = emitted_q;

endmodule

// File: tb/tb_branch_trace_feeder.sv
// Scoreboard bench for branch_trace_feeder.
// Accepted records are queued; replayed records are popped and compared.
module tb_branch_trace_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_pc = '0;
  logic        in_taken = 1'b0;
  logic        in_last = 1'b0;
  logic        run = 1'b0;
  logic        out_valid;
  logic [8:0]  out_pc;
  logic        out_taken;
  logic        done;
  logic [4:0]  level;
  logic [31:0] emitted;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int cur_run = 0;
  int max_run = 0;
  int base;
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;

  branch_trace_feeder #(
    .DEPTH (16),
    .PC_W  (9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_taken  (in_taken),
    .in_last   (in_last),
    .run       (run),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_taken (out_taken),
    .done      (done),
    .level     (level),
    .emitted   (emitted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every accepted handshake as an expected output.
  always @(posedge clk) begin
    if (reset && in_valid && in_ready)
      exp_q.push_back({in_pc, in_taken});
  end

  // Compare every presented record against the queue head.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_out++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (exp_q.size() == 0) begin
        chk("sb_extra", out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", out_pc, mon_e[9:1]);
        chk("sb_taken", out_taken, mon_e[0]);
      end
    end else begin
      cur_run = 0;
    end
  end

  task automatic send(input logic [8:0] pc, input logic t,
                      input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_taken = t;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    // reset then idle
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_emit", emitted, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_level", level, 0);
    chk("idle_valid", out_valid, 0);

    // basic replay
    send(9'h005, 1'b1, 1'b0);
    send(9'h006, 1'b0, 1'b0);
    send(9'h007, 1'b1, 1'b1);
    chk("basic_level", level, 3);
    run = 1'b1;
    @(negedge clk);
    chk("basic_v0", out_valid, 1);
    chk("basic_pc0", out_pc, 9'h005);
    @(negedge clk);
    chk("basic_pc1", out_pc, 9'h006);
    @(negedge clk);
    chk("basic_pc2", out_pc, 9'h007);
    chk("basic_v2", out_valid, 1);
    chk("basic_emit", emitted, 3);
    @(negedge clk);
    chk("basic_vend", out_valid, 0);
    chk("basic_done", done, 1);
    chk("basic_ready", in_ready, 0);
    run = 1'b0;
    @(negedge clk);
    chk("leave_done", done, 0);
    chk("leave_emit", emitted, 0);
    chk("leave_ready", in_ready, 1);

    // full / backpressure with pointer wrap
    for (int i = 0; i < 16; i++)
      send(9'(9'h100 + i), i[0], 1'b0);
    chk("full_level", level, 16);
    chk("full_ready", in_ready, 0);
    fork
      begin
        for (int i = 16; i < 20; i++)
          send(9'(9'h100 + i), i[0], i == 19);
      end
      begin
        repeat (3) @(negedge clk);
        chk("full_hold", level, 16);
        chk("full_hold_rdy", in_ready, 0);
        run = 1'b1;
      end
    join
    wait_done("bp_done");
    chk("bp_emit", emitted, 20);
    run = 1'b0;
    @(negedge clk);
    chk("bp_clear", emitted, 0);

    // underflow stall: one record every three cycles
    run = 1'b1;
    max_run = 0;
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      send(9'(9'h040 + i), i[0], i == 5);
      if (i < 5) repeat (2) @(negedge clk);
    end
    wait_done("uf_done");
    chk("uf_count", n_out - base, 6);
    chk("uf_pulse", max_run, 1);
    chk("uf_emit", emitted, 6);
    run = 1'b0;
    @(negedge clk);

    // run dropped mid-trace
    for (int i = 0; i < 5; i++)
      send(9'(9'h0A0 + i), ~i[0], i == 4);
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("pause_valid", out_valid, 0);
    chk("pause_level", level, 3);
    chk("pause_emit", emitted, 2);
    repeat (2) @(negedge clk);
    chk("pause_hold", out_valid, 0);
    run = 1'b1;
    wait_done("pause_done");
    chk("pause_emit5", emitted, 5);
    run = 1'b0;
    @(negedge clk);

    // reset while replaying
    for (int i = 0; i < 9; i++)
      send(9'(9'h1C0 + i), i[0], 1'b0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_pre", level, 7);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_level", level, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 0);
    chk("mrst_emit", emitted, 0);
    reset = 1'b1;
    base = n_out;
    repeat (5) @(negedge clk);
    chk("mrst_silent", n_out - base, 0);
    chk("mrst_empty", level, 0);
    send(9'h1FF, 1'b1, 1'b1);
    wait_done("mrst_done");
    chk("mrst_emit1", emitted, 1);
    run = 1'b0;
    @(negedge clk);

    chk("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
